// File: rtl/reg_file_bank.sv
// Register bank for the simpleCPU datapath: one write port, two combinational read
// ports with optional write-through bypass, and a per-register pending scoreboard.
module reg_file_bank #(
   parameter int  WIDTH     = 8,
   parameter int  NREG      = 8,
   parameter int  ZERO_REG0 = 1,
   parameter int  BYPASS    = 1,
   localparam int AW        = $clog2(NREG)
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             WrEn,
   input  logic [AW-1:0]    WrAddr,
   input  logic [WIDTH-1:0] WrData,
   input  logic [AW-1:0]    RdAddrA,
   output logic [WIDTH-1:0] RdDataA,
   input  logic [AW-1:0]    RdAddrB,
   output logic [WIDTH-1:0] RdDataB,
   input  logic             IssEn,
   input  logic [AW-1:0]    IssAddr,
   output logic             PendA,
   output logic             PendB,
   output logic             PendAny
);

   logic [WIDTH-1:0] r_regs [NREG];
   logic [NREG-1:0]  r_pend;

   logic w_wr_ok;
   logic w_iss_ok;
   logic w_zero_a;
   logic w_zero_b;
   logic w_byp_a;
   logic w_byp_b;

   // Register 0 is hard-wired to zero: its writes and issues are simply dropped.
   assign w_wr_ok  = WrEn  && !((ZERO_REG0 != 0) && (WrAddr  == '0));
   assign w_iss_ok = IssEn && !((ZERO_REG0 != 0) && (IssAddr == '0));
   assign w_zero_a = (ZERO_REG0 != 0) && (RdAddrA == '0);
   assign w_zero_b = (ZERO_REG0 != 0) && (RdAddrB == '0);
   // Bypass is suppressed while Rst is high so the read ports stay at zero during reset.
   assign w_byp_a  = (BYPASS != 0) && !Rst && w_wr_ok && (WrAddr == RdAddrA);
   assign w_byp_b  = (BYPASS != 0) && !Rst && w_wr_ok && (WrAddr == RdAddrB);

   // NOTE: the whole array is reset because software may read any register straight
   // after reset; that rules out a RAM macro, which is fine at this size.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
         r_pend <= '0;
      end else begin
         if (w_wr_ok) begin
            r_regs[WrAddr] <= WrData;
            r_pend[WrAddr] <= 1'b0;
         end
         // NOTE: non-blocking updates let the later issue assignment override the
         // write-back clear on the same index, so issue wins without extra logic.
         if (w_iss_ok) r_pend[IssAddr] <= 1'b1;
      end
   end

   // NOTE: every output gets its default first so no path through the block infers a latch.
   always_comb begin
      RdDataA = r_regs[RdAddrA];
      PendA   = r_pend[RdAddrA];
      if (w_zero_a) begin
         RdDataA = '0;
         PendA   = 1'b0;
      end else if (w_byp_a) begin
         RdDataA = WrData;
      end
   end

   always_comb begin
      RdDataB = r_regs[RdAddrB];
      PendB   = r_pend[RdAddrB];
      if (w_zero_b) begin
         RdDataB = '0;
         PendB   = 1'b0;
      end else if (w_byp_b) begin
         RdDataB = WrData;
      end
   end

   assign PendAny = |r_pend;

endmodule

// File: tb/tb_reg_file_bank.sv
// Directed bench: one bypassing and one non-bypassing bank share stimulus; a vector
// table covers read/write/issue behaviour, hand sequences cover reset corner cases.
module tb_reg_file_bank;

   localparam int WIDTH = 8;
   localparam int NREG  = 8;
   localparam int AW    = 3;

   logic             clk;
   logic             rst;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [AW-1:0]    rd_addr_a;
   logic [AW-1:0]    rd_addr_b;
   logic             iss_en;
   logic [AW-1:0]    iss_addr;

   logic [WIDTH-1:0] byp_a, byp_b, nob_a, nob_b;
   logic             byp_pa, byp_pb, byp_any;
   logic             nob_pa, nob_pb, nob_any;

   int n_checks = 0;
   int n_errors = 0;

   reg_file_bank #(.WIDTH(WIDTH), .NREG(NREG), .ZERO_REG0(1), .BYPASS(1)) u_byp (
      .Clk(clk), .Rst(rst), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
      .RdAddrA(rd_addr_a), .RdDataA(byp_a), .RdAddrB(rd_addr_b), .RdDataB(byp_b),
      .IssEn(iss_en), .IssAddr(iss_addr), .PendA(byp_pa), .PendB(byp_pb), .PendAny(byp_any)
   );

   reg_file_bank #(.WIDTH(WIDTH), .NREG(NREG), .ZERO_REG0(1), .BYPASS(0)) u_nob (
      .Clk(clk), .Rst(rst), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
      .RdAddrA(rd_addr_a), .RdDataA(nob_a), .RdAddrB(rd_addr_b), .RdDataB(nob_b),
      .IssEn(iss_en), .IssAddr(iss_addr), .PendA(nob_pa), .PendB(nob_pb), .PendAny(nob_any)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             wr_en;
      logic [AW-1:0]    wr_addr;
      logic [WIDTH-1:0] wr_data;
      logic             iss_en;
      logic [AW-1:0]    iss_addr;
      logic [AW-1:0]    rd_a;
      logic [AW-1:0]    rd_b;
      logic [WIDTH-1:0] exp_a;    // bypassing bank
      logic [WIDTH-1:0] exp_b;
      logic [WIDTH-1:0] exp_na;   // non-bypassing bank
      logic [WIDTH-1:0] exp_nb;
      logic             exp_pa;
      logic             exp_pb;
      logic             exp_any;
   } vec_t;

   localparam int NVEC = 15;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_both_a(input string name, input logic [WIDTH-1:0] exp);
      check({name, " byp A"}, 32'(byp_a), 32'(exp));
      check({name, " nob A"}, 32'(nob_a), 32'(exp));
   endtask

   initial begin
      // Expected values are the pre-edge read-port view of each cycle.
      //           we   wa    wd     ie   ia    ra    rb    ea     eb     ena    enb    pa    pb    any
      vecs[0]  = '{1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 3'd3, 3'd0, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 3'd3, 8'hFF, 1'b0, 3'd0, 3'd3, 3'd3, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 3'd5, 8'h3C, 1'b0, 3'd0, 3'd3, 3'd5, 8'hA5, 8'h3C, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd2, 3'd5, 8'h00, 8'h3C, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd3, 8'h00, 8'hA5, 8'h00, 8'hA5, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 3'd2, 3'd2, 8'h11, 8'h11, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1};
      vecs[6]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd5, 8'h11, 8'h3C, 8'h11, 8'h3C, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 3'd2, 8'h22, 1'b1, 3'd2, 3'd2, 3'd3, 8'h22, 8'hA5, 8'h11, 8'hA5, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd2, 3'd0, 8'h22, 8'h00, 8'h22, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 3'd0, 8'h77, 1'b1, 3'd0, 3'd0, 3'd2, 8'h00, 8'h22, 8'h00, 8'h22, 1'b0, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 3'd2, 8'h5A, 1'b0, 3'd0, 3'd0, 3'd7, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{1'b1, 3'd7, 8'hC3, 1'b1, 3'd6, 3'd7, 3'd2, 8'hC3, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd6, 3'd7, 8'h00, 8'hC3, 8'h00, 8'hC3, 1'b1, 1'b0, 1'b1};
      vecs[13] = '{1'b1, 3'd6, 8'h81, 1'b0, 3'd0, 3'd6, 3'd1, 8'h81, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[14] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd6, 3'd6, 8'h81, 8'h81, 8'h81, 8'h81, 1'b0, 1'b0, 1'b0};

      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_addr_a = 3'd3; rd_addr_b = 3'd5; iss_en = 1'b0; iss_addr = '0;

      // Power-on reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset byp A", 32'(byp_a), 32'h0);
      check("reset nob B", 32'(nob_b), 32'h0);
      check("reset PendAny", 32'(byp_any | nob_any), 32'h0);
      rst = 1'b0;

      // Table-driven main function
      for (int i = 0; i < NVEC; i++) begin
         @(posedge clk);
         #1;
         wr_en = vecs[i].wr_en;   wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
         iss_en = vecs[i].iss_en; iss_addr = vecs[i].iss_addr;
         rd_addr_a = vecs[i].rd_a; rd_addr_b = vecs[i].rd_b;
         @(negedge clk);
         check($sformatf("v%0d byp A", i), 32'(byp_a), 32'(vecs[i].exp_a));
         check($sformatf("v%0d byp B", i), 32'(byp_b), 32'(vecs[i].exp_b));
         check($sformatf("v%0d nob A", i), 32'(nob_a), 32'(vecs[i].exp_na));
         check($sformatf("v%0d nob B", i), 32'(nob_b), 32'(vecs[i].exp_nb));
         check($sformatf("v%0d PendA", i), 32'({byp_pa, nob_pa}), 32'({2{vecs[i].exp_pa}}));
         check($sformatf("v%0d PendB", i), 32'({byp_pb, nob_pb}), 32'({2{vecs[i].exp_pb}}));
         check($sformatf("v%0d PendAny", i), 32'({byp_any, nob_any}), 32'({2{vecs[i].exp_any}}));
      end

      // Asynchronous reset between edges clears data and pending immediately
      @(posedge clk);
      #1;
      wr_en = 1'b0; iss_en = 1'b1; iss_addr = 3'd4;
      rd_addr_a = 3'd6; rd_addr_b = 3'd7;
      @(posedge clk);
      #1;
      iss_en = 1'b0;
      #1;
      check("pre-rst A", 32'(byp_a), 32'h81);
      check("pre-rst B", 32'(byp_b), 32'hC3);
      check("pre-rst PendAny", 32'(byp_any), 32'h1);
      rst = 1'b1;
      #1;
      check("async rst A", 32'(byp_a), 32'h0);
      check("async rst nob B", 32'(nob_b), 32'h0);
      check("async rst PendAny", 32'({byp_any, nob_any}), 32'h0);

      // Write coincident with reset is lost; bypass stays quiet while Rst is high
      @(posedge clk);
      #1;
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h99; rd_addr_a = 3'd1;
      #1;
      check_both_a("rst+wr", 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b0; wr_en = 1'b0;
      @(negedge clk);
      check_both_a("post-rst reg1", 8'h00);
      @(posedge clk);
      #1;
      wr_en = 1'b1; wr_data = 8'h12;
      @(negedge clk);
      check("first wr byp A", 32'(byp_a), 32'h12);
      check("first wr nob A", 32'(nob_a), 32'h00);
      @(posedge clk);
      #1;
      wr_en = 1'b0; wr_data = 8'hFF;
      @(negedge clk);
      check_both_a("first wr held", 8'h12);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
